spi_accel_responder: RTL and testbench

SPI mode-0 slave that models the accelerometer at the far end of our SPI read path. It decodes the instruction byte (0x0A write, 0x0B read), then the address byte, then streams data bytes with address auto-increment. It serves a small register map: device ID, X/Y/Z sample registers, a status register and a scratch bank. It is used as the on-board stand-in for the sensor and as the bus-functional responder in system benches.

---
 rtl/spi_accel_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 49 ++++
 rtl/spi_accel_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_accel_pkg.sv
// Shared opcodes, register addresses and FSM encoding for the SPI accelerometer responder.
package spi_accel_pkg;

   localparam logic [7:0] OP_WRITE          = 8'h0A;
   localparam logic [7:0] OP_READ           = 8'h0B;

   localparam logic [7:0] ADDR_DEVID        = 8'h00;
   localparam logic [7:0] ADDR_XDATA        = 8'h08;
   localparam logic [7:0] ADDR_YDATA        = 8'h09;
   localparam logic [7:0] ADDR_ZDATA        = 8'h0A;
   localparam logic [7:0] ADDR_STATUS       = 8'h0B;
   localparam logic [7:0] ADDR_SCRATCH_BASE = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_IGNORE
   } state_t;

   // Scratch bank occupies the 16-byte window 0x20-0x2F.
   function automatic logic is_scratch(input logic [7:0] addr);
      return addr[7:4] == ADDR_SCRATCH_BASE[7:4];
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes sclk/ss_n/mosi into clk and derives one-clk sclk rise/fall strobes.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sclk,
   input  logic ss_n,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ss_n_s,
   output logic mosi_s
);

   logic [2:0] pins;
   logic [2:0] synced;
   logic       sclk_d_reg;

   assign pins = {mosi, ss_n, sclk};

   // ss_n chain resets low so a select already asserted at reset release never looks like a fresh falling edge.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               chain_reg <= '0;
            else
               chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
         end
         assign synced[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sclk_d_reg <= 1'b0;
      else
         sclk_d_reg <= synced[0];
   end

   assign sclk_rise = synced[0] & ~sclk_d_reg;
   assign sclk_fall = ~synced[0] & sclk_d_reg;
   assign ss_n_s    = synced[1];
   assign mosi_s    = synced[2];

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating the accelerometer: instruction/address decode, auto-increment
// burst access, sample registers with tear-free deferred capture, and a scratch bank.
module spi_accel_responder
   import spi_accel_pkg::*;
#(
   parameter logic [7:0] DEVID       = 8'hAD,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic       sample_valid,
   input  logic [7:0] x_in,
   input  logic [7:0] y_in,
   input  logic [7:0] z_in,
   output logic       int1
);

   logic sclk_rise, sclk_fall, ss_n_s, mosi_s;

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .sclk      (sclk),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .ss_n_s    (ss_n_s),
      .mosi_s    (mosi_s)
   );

   state_t     state_reg, state_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] addr_reg, addr_next;
   logic [7:0] tx_reg, tx_next;
   logic       is_read_reg, is_read_next;
   logic       ss_n_prev_reg;
   logic       ss_n_fall;

   logic [7:0] x_reg, x_next, y_reg, y_next, z_reg, z_next;
   logic [7:0] px_reg, px_next, py_reg, py_next, pz_reg, pz_next;
   logic       pending_reg, pending_next;
   logic       ready_reg, ready_next;
   logic       int1_reg;

   logic [7:0] byte_in;
   logic       scratch_we;
   logic       ready_clear;
   logic [7:0] rd_data;
   logic [7:0] scratch_q [16];

   assign ss_n_fall = ss_n_prev_reg & ~ss_n_s;
   assign byte_in   = {shift_reg[6:0], mosi_s};

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= 3'd0;
         shift_reg     <= 8'd0;
         addr_reg      <= 8'd0;
         tx_reg        <= 8'd0;
         is_read_reg   <= 1'b0;
         ss_n_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         addr_reg      <= addr_next;
         tx_reg        <= tx_next;
         is_read_reg   <= is_read_next;
         ss_n_prev_reg <= ss_n_s;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      addr_next    = addr_reg;
      tx_next      = tx_reg;
      is_read_next = is_read_reg;
      scratch_we   = 1'b0;
      ready_clear  = 1'b0;

      if (ss_n_s) begin
         state_next   = ST_IDLE;
         bit_cnt_next = 3'd0;
         shift_next   = 8'd0;
         tx_next      = 8'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (ss_n_fall) begin
                  state_next   = ST_CMD;
                  bit_cnt_next = 3'd0;
               end
            end
            ST_CMD, ST_ADDR, ST_WR_DATA: begin
               if (sclk_rise) begin
                  shift_next   = byte_in;
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     if (state_reg == ST_CMD) begin
                        if (byte_in == OP_READ) begin
                           state_next   = ST_ADDR;
                           is_read_next = 1'b1;
                        end else if (byte_in == OP_WRITE) begin
                           state_next   = ST_ADDR;
                           is_read_next = 1'b0;
                        end else begin
                           state_next   = ST_IGNORE;
                        end
                     end else if (state_reg == ST_ADDR) begin
                        addr_next  = byte_in;
                        state_next = is_read_reg ? ST_RD_DATA : ST_WR_DATA;
                     end else begin
                        scratch_we = is_scratch(addr_reg);
                        addr_next  = addr_reg + 8'd1;
                     end
                  end
               end
            end
            ST_RD_DATA: begin
               // Load on the fall ahead of the byte so bit 7 is on MISO before the first sampling rise.
               if (sclk_fall)
                  tx_next = (bit_cnt_reg == 3'd0) ? rd_data : {tx_reg[6:0], 1'b0};
               if (sclk_rise) begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     addr_next   = addr_reg + 8'd1;
                     ready_clear = (addr_reg == ADDR_YDATA);
                  end
               end
            end
            ST_IGNORE: begin
               state_next = ST_IGNORE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------- register map read ----------------
   always_comb begin
      rd_data = 8'd0;
      case (addr_reg)
         ADDR_DEVID:  rd_data = DEVID;
         ADDR_XDATA:  rd_data = x_reg;
         ADDR_YDATA:  rd_data = y_reg;
         ADDR_ZDATA:  rd_data = z_reg;
         ADDR_STATUS: rd_data = {7'd0, ready_reg};
         default: begin
            if (is_scratch(addr_reg))
               rd_data = scratch_q[addr_reg[3:0]];
         end
      endcase
   end

   // ---------------- scratch bank ----------------
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_scratch
         logic [7:0] entry_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               entry_reg <= 8'd0;
            else if (scratch_we && addr_reg[3:0] == 4'(gi))
               entry_reg <= byte_in;
         end
         assign scratch_q[gi] = entry_reg;
      end
   endgenerate

   // ---------------- sample capture ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_reg       <= 8'd0;
         y_reg       <= 8'd0;
         z_reg       <= 8'd0;
         px_reg      <= 8'd0;
         py_reg      <= 8'd0;
         pz_reg      <= 8'd0;
         pending_reg <= 1'b0;
         ready_reg   <= 1'b0;
         int1_reg    <= 1'b0;
      end else begin
         x_reg       <= x_next;
         y_reg       <= y_next;
         z_reg       <= z_next;
         px_reg      <= px_next;
         py_reg      <= py_next;
         pz_reg      <= pz_next;
         pending_reg <= pending_next;
         ready_reg   <= ready_next;
         int1_reg    <= ready_next;
      end
   end

   // Samples only land between transactions so a burst never mixes old and new axes.
   always_comb begin
      x_next       = x_reg;
      y_next       = y_reg;
      z_next       = z_reg;
      px_next      = px_reg;
      py_next      = py_reg;
      pz_next      = pz_reg;
      pending_next = pending_reg;
      ready_next   = ready_reg;

      if (ready_clear)
         ready_next = 1'b0;

      if (ss_n_s) begin
         if (sample_valid) begin
            x_next       = x_in;
            y_next       = y_in;
            z_next       = z_in;
            ready_next   = 1'b1;
            pending_next = 1'b0;
         end else if (pending_reg) begin
            x_next       = px_reg;
            y_next       = py_reg;
            z_next       = pz_reg;
            ready_next   = 1'b1;
            pending_next = 1'b0;
         end
      end else if (sample_valid) begin
         px_next      = x_in;
         py_next      = y_in;
         pz_next      = z_in;
         pending_next = 1'b1;
      end
   end

   assign miso_oe = (state_reg == ST_RD_DATA);
   assign miso    = miso_oe & tx_reg[7];
   assign int1    = int1_reg;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Scoreboard bench: a mode-0 SPI master drives the responder; expected read bytes are queued up front.
module tb_spi_accel_responder;
   import spi_accel_pkg::*;

   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sclk = 1'b0;
   logic       ss_n = 1'b1;
   logic       mosi = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] x_in = 8'd0;
   logic [7:0] y_in = 8'd0;
   logic [7:0] z_in = 8'd0;
   logic       miso, miso_oe, int1;

   int         n_checks = 0;
   int         n_fail = 0;
   int         oe_count = 0;
   logic [7:0] exp_q [$];

   spi_accel_responder dut (
      .clk          (clk),
      .reset        (reset),
      .sclk         (sclk),
      .ss_n         (ss_n),
      .mosi         (mosi),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .sample_valid (sample_valid),
      .x_in         (x_in),
      .y_in         (y_in),
      .z_in         (z_in),
      .int1         (int1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (miso_oe) oe_count++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         #HALF;
         rx[i] = miso;
         sclk = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic xfer_start;
      ss_n = 1'b0;
      #(2*HALF);
   endtask

   task automatic xfer_end;
      #HALF;
      ss_n = 1'b1;
      #(3*HALF);
   endtask

   task automatic pulse_sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
      @(negedge clk);
      x_in = x; y_in = y; z_in = z;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // Leaves ss_n low so the caller can probe state before closing the transaction.
   task automatic read_bytes(input logic [7:0] a, input int n);
      logic [7:0] rx;
      logic [7:0] ad;
      xfer_start;
      spi_byte(OP_READ, rx);
      spi_byte(a, rx);
      for (int i = 0; i < n; i++) begin
         ad = a + 8'(i);
         spi_byte(8'h00, rx);
         $display("read  addr 0x%02h -> 0x%02h", ad, rx);
         if (exp_q.size() == 0)
            check_val("scoreboard_underrun", 32'd1, 32'd0);
         else
            check_val($sformatf("rd_0x%02h", ad), {24'd0, rx}, {24'd0, exp_q.pop_front()});
      end
   endtask

   initial begin
      #300_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rx;
      int         oe_snap;

      // Reset state
      #25;
      check_val("rst_miso", miso, 0);
      check_val("rst_miso_oe", miso_oe, 0);
      check_val("rst_int1", int1, 0);
      #15 reset = 1'b0;
      #100;

      // Single Y read: 0x5A, int1 falls at the end of the byte
      pulse_sample(8'h00, 8'h5A, 8'h00);
      #50;
      check_val("int1_after_sample", int1, 1);
      exp_q.push_back(8'h5A);
      xfer_start;
      spi_byte(OP_READ, rx);
      spi_byte(ADDR_YDATA, rx);
      check_val("rd_oe_active", miso_oe, 1);
      check_val("int1_before_ybyte", int1, 1);
      spi_byte(8'h00, rx);
      $display("read  addr 0x09 -> 0x%02h", rx);
      check_val("rd_y_5a", {24'd0, rx}, {24'd0, exp_q.pop_front()});
      check_val("int1_after_ybyte", int1, 0);
      xfer_end;
      check_val("idle_oe", miso_oe, 0);

      // Burst across X/Y/Z/STATUS, then DEVID
      pulse_sample(8'h11, 8'h22, 8'h33);
      #50;
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_q.push_back(8'h33); exp_q.push_back(8'h00);
      read_bytes(ADDR_XDATA, 4);
      xfer_end;
      exp_q.push_back(8'hAD);
      read_bytes(ADDR_DEVID, 1);
      xfer_end;

      // Write scratch[15], second byte lands on 0x30 and is dropped
      xfer_start;
      spi_byte(OP_WRITE, rx);
      spi_byte(8'h2F, rx);
      spi_byte(8'hA5, rx);
      spi_byte(8'h3C, rx);
      xfer_end;
      $display("write addr 0x2F <- 0xA5, 0x3C");
      exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
      read_bytes(8'h2F, 2);
      xfer_end;

      // Bad opcode: bytes that would otherwise write 0xFF to 0x20
      oe_snap = oe_count;
      xfer_start;
      spi_byte(8'h55, rx);
      spi_byte(8'h20, rx);
      spi_byte(8'hFF, rx);
      check_val("ignore_miso", {24'd0, rx}, 32'd0);
      xfer_end;
      $display("bad opcode 0x55 + 16 clocks");
      check_val("ignore_oe_cycles", oe_count - oe_snap, 0);
      exp_q.push_back(8'h00);
      read_bytes(8'h20, 1);
      xfer_end;
      exp_q.push_back(8'hA5);
      read_bytes(8'h2F, 1);
      xfer_end;

      // Deferral: new Y during a read of Y is held until ss_n rises
      pulse_sample(8'h00, 8'h44, 8'h00);
      #50;
      exp_q.push_back(8'h44);
      xfer_start;
      spi_byte(OP_READ, rx);
      spi_byte(ADDR_YDATA, rx);
      pulse_sample(8'h00, 8'h77, 8'h00);
      spi_byte(8'h00, rx);
      $display("read  addr 0x09 -> 0x%02h (sample deferred)", rx);
      check_val("rd_y_old", {24'd0, rx}, {24'd0, exp_q.pop_front()});
      check_val("int1_cleared_in_burst", int1, 0);
      xfer_end;
      check_val("int1_pending_applied", int1, 1);
      exp_q.push_back(8'h77);
      read_bytes(ADDR_YDATA, 1);
      xfer_end;

      // Abort after 3 bits of a write data byte
      xfer_start;
      spi_byte(OP_WRITE, rx);
      spi_byte(8'h21, rx);
      for (int i = 0; i < 3; i++) begin
         mosi = 1'b1;
         #HALF;
         sclk = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
      xfer_end;
      $display("write addr 0x21 aborted after 3 bits");
      exp_q.push_back(8'h00);
      read_bytes(8'h21, 1);
      xfer_end;

      // Reset mid-burst, released with ss_n still low
      pulse_sample(8'h00, 8'h99, 8'h00);
      #50;
      xfer_start;
      spi_byte(OP_READ, rx);
      spi_byte(8'h2F, rx);
      for (int i = 0; i < 4; i++) begin
         #HALF;
         sclk = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
      reset = 1'b1;
      #1;
      check_val("midrst_miso", miso, 0);
      check_val("midrst_miso_oe", miso_oe, 0);
      check_val("midrst_int1", int1, 0);
      #39;
      reset = 1'b0;
      #60;
      oe_snap = oe_count;
      spi_byte(OP_READ, rx);
      spi_byte(8'h2F, rx);
      spi_byte(8'h00, rx);
      check_val("post_rst_lowss_miso", {24'd0, rx}, 32'd0);
      check_val("post_rst_lowss_oe", oe_count - oe_snap, 0);
      xfer_end;
      $display("reset mid-burst, ss_n held low at release");
      exp_q.push_back(8'h00);
      read_bytes(ADDR_YDATA, 1);
      xfer_end;
      exp_q.push_back(8'h00);
      read_bytes(8'h2F, 1);
      xfer_end;
      exp_q.push_back(8'hAD);
      read_bytes(ADDR_DEVID, 1);
      xfer_end;

      check_val("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
